// File: rtl/calc_keypad_core.sv
// Calculator key handling: hex digit entry plus add/subtract with a pending operator.
// All state, including the displayed value, is registered; a key acts on the edge that samples it.
module calc_keypad_core #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         key_inc,
  input  logic         key_shift,
  input  logic         key_add,
  input  logic         key_sub,
  input  logic         key_equal,
  input  logic         key_clear,
  output logic [W-1:0] display,
  output logic [1:0]   mode,
  output logic         op_pending,
  output logic         carry
);

  typedef enum logic [1:0] {ST_ENTRY = 2'd0, ST_OPER = 2'd1, ST_RESULT = 2'd2} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2} op_t;

  state_t       state_q, state_d;
  op_t          op_q, op_d;
  logic [W-1:0] e_q, e_d;
  logic [W-1:0] a_q, a_d;
  logic         carry_q, carry_d;
  logic [W-1:0] display_q, display_d;

  logic [W:0]   sum_w, diff_w;
  logic [W-1:0] eval_res;
  logic         eval_carry;
  op_t          key_op;

  // The top bit of the widened difference is the borrow, i.e. A < E unsigned.
  assign sum_w  = {1'b0, a_q} + {1'b0, e_q};
  assign diff_w = {1'b0, a_q} - {1'b0, e_q};
  assign key_op = key_add ? OP_ADD : OP_SUB;

  always_comb begin
    eval_res   = e_q;
    eval_carry = carry_q;
    case (op_q)
      OP_ADD: begin
        eval_res   = sum_w[W-1:0];
        eval_carry = sum_w[W];
      end
      OP_SUB: begin
        eval_res   = diff_w[W-1:0];
        eval_carry = diff_w[W];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    e_d     = e_q;
    a_d     = a_q;
    carry_d = carry_q;
    if (key_clear) begin
      state_d = ST_ENTRY;
      op_d    = OP_NONE;
      e_d     = '0;
      a_d     = '0;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (key_equal) begin
            a_d     = eval_res;
            carry_d = eval_carry;
            op_d    = OP_NONE;
            state_d = ST_RESULT;
          end else if (key_add || key_sub) begin
            a_d     = eval_res;
            carry_d = eval_carry;
            op_d    = key_op;
            e_d     = '0;
            state_d = ST_OPER;
          end else if (key_shift) begin
            e_d = {e_q[W-5:0], 4'h0};
          end else if (key_inc) begin
            e_d = {e_q[W-1:4], e_q[3:0] + 4'd1};
          end
        end
        ST_OPER: begin
          // Evaluating against an empty operand leaves A as is and clears carry.
          if (key_equal) begin
            carry_d = 1'b0;
            op_d    = OP_NONE;
            state_d = ST_RESULT;
          end else if (key_add || key_sub) begin
            op_d = key_op;
          end else if (key_inc && !key_shift) begin
            e_d     = {{(W-1){1'b0}}, 1'b1};
            state_d = ST_ENTRY;
          end
        end
        ST_RESULT: begin
          if (key_equal) begin
            state_d = ST_RESULT;
          end else if (key_add || key_sub) begin
            op_d    = key_op;
            e_d     = '0;
            state_d = ST_OPER;
          end else if (key_inc && !key_shift) begin
            e_d     = {{(W-1){1'b0}}, 1'b1};
            op_d    = OP_NONE;
            state_d = ST_ENTRY;
          end
        end
        default: state_d = ST_ENTRY;
      endcase
    end
    display_d = (state_d == ST_ENTRY) ? e_d : a_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ENTRY;
      op_q      <= OP_NONE;
      e_q       <= '0;
      a_q       <= '0;
      carry_q   <= 1'b0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      e_q       <= e_d;
      a_q       <= a_d;
      carry_q   <= carry_d;
      display_q <= display_d;
    end
  end

  assign display    = display_q;
  assign mode       = state_q;
  assign op_pending = (op_q != OP_NONE);
  assign carry      = carry_q;

endmodule

// File: doc/calc_keypad_core.md
# calc_keypad_core

Calculator key-handling and arithmetic stage that sits directly downstream of the per-button debouncers. It consumes their one-cycle `push` pulses and builds a hexadecimal operand digit by digit. It applies add/subtract with a pending-operator model and drives a registered value for the seven-segment display driver. All inputs are single-cycle pulses in the `clock` domain.

## Interface
- `W`, default 16: operand/accumulator width in bits; must be a multiple of 4 (W/4 hex digits).
- `clock`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `key_inc`  input  1  push pulse: increment the least-significant digit of the entry.
- `key_shift`  input  1  push pulse: shift the entry left one digit.
- `key_add`  input  1  push pulse: select the add operator.
- `key_sub`  input  1  push pulse: select the subtract operator.
- `key_equal`  input  1  push pulse: evaluate the pending operation.
- `key_clear`  input  1  push pulse: clear everything.
- `display`  output  W  value to show; registered.
- `mode`  output  2  current FSM state: 0 ENTRY, 1 OPER, 2 RESULT.
- `op_pending`  output  1  an operator is latched and not yet evaluated.
- `carry`  output  1  carry (add) or borrow (sub) of the last evaluation.

## Operation
- Internal registers:
  - `E` (entry, W bits)
  - `A` (accumulator, W bits)
  - `OP` (NONE/ADD/SUB)
  - state.
- Key priority, when several pulses fall in one cycle: clear > equal > add > sub > shift > inc. Only the highest-priority key is acted on; the others are dropped.
- Evaluation f(A,E):
  - ADD: A+E mod 2^W, carry = bit W of the sum.
  - SUB: A−E mod 2^W, carry = (A < E) unsigned.
  - Evaluation with OP=NONE: result E, carry unchanged.
- ENTRY state (display = E):
  - inc: E[3:0] <= E[3:0]+1, wrapping F->0; upper digits untouched (no carry into digit 1).
  - shift: E <= {E[W-5:0],4'h0}; the top digit is lost.
  - add/sub: A <= f(A,E); OP <= ADD/SUB; E <= 0; go to OPER.
  - equal: A <= f(A,E); OP <= NONE; go to RESULT.
- OPER state (display = A):
  - inc: E <= 1; go to ENTRY.
  - shift: ignored.
  - add/sub: only replaces OP; no evaluation; carry unchanged.
  - equal: A <= f(A,0), i.e. A unchanged, carry 0; OP <= NONE; go to RESULT.
- RESULT state (display = A):
  - inc: E <= 1; OP <= NONE; go to ENTRY. A is kept but is overwritten by the next evaluation, since OP=NONE yields E.
  - shift: ignored.
  - add/sub: OP set; E <= 0; go to OPER (chains on the result).
  - equal: ignored.
- clear, from any state: A=E=0, OP=NONE, carry=0, go to ENTRY.
- `op_pending` = (OP != NONE).
- `mode` encodes the state; encoding 3 is unreachable, and if entered the FSM recovers to ENTRY on the next edge.

## Timing
- Reset (asynchronous assert, synchronous release by design): `display`=0, `mode`=0, `op_pending`=0, `carry`=0; A=E=0, OP=NONE.
- A pulse sampled high at rising edge N updates all registers and outputs at edge N.
  - Outputs are valid after that edge: one-cycle latency, no combinational path from keys to outputs.
- Back-to-back pulses on consecutive cycles are each processed; no key is lost except by the priority rule.
- Held-high key (not produced by a debouncer, but tolerated): acts once per cycle.
- `display` is updated in the same edge as the state change, so it is always consistent with `mode`.
- Reset asserted mid-operation: all outputs go to reset values immediately, asynchronously; pending OP and entry are discarded.

## Test plan
- Reset, then inc ×3, shift, inc ×2 -> display 0x0032, mode 0, op_pending 0.
- Entry 0x00FF, add, entry 0x0001, equal -> after add: display 0x00FF, mode 1; after equal: display 0x0100, carry 0, mode 2.
- Entry 0x0003, sub, entry 0x0005, equal -> display 0xFFFE, carry 1. Then add, inc, equal -> display 0xFFFF, carry 0.
- Entry 0xF000 via inc×15 + shift×3; add; entry 0x1000; equal -> display 0x0000, carry 1. Also inc ×16 from 0 -> digit wraps to 0x0000.
- key_clear and key_add in the same cycle while op_pending -> all cleared, mode 0. key_add and key_inc together -> add wins; E digit unchanged.
- Reset pulsed low mid-entry (E=0x0042, OP=ADD) between edges -> outputs 0 immediately, before the next clock edge; after release, inc -> display 0x0001.
